// File: rtl/mod_segment_ctrl.sv
// Modulation segment controller: double-buffered settings, transition sequencing
// and sample index generation. Optional GPIO trigger: MOD_SEG_CTRL_GPIO_TRIG_EN.
module mod_segment_ctrl #(
    parameter int IDX_W            = 15,
    parameter int SYNC_IDX_TIMEOUT = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UPDATE,
    input  logic             REQ_RD_SEGMENT,
    input  logic [7:0]       TRANSITION_MODE,
    input  logic [63:0]      TRANSITION,
    input  logic [IDX_W-1:0] CYCLE0,
    input  logic [IDX_W-1:0] CYCLE1,
    input  logic [15:0]      FREQ_DIV0,
    input  logic [15:0]      FREQ_DIV1,
    input  logic [15:0]      REP0,
    input  logic [15:0]      REP1,
    input  logic [63:0]      SYS_TIME,
`ifdef MOD_SEG_CTRL_GPIO_TRIG_EN
    input  logic             GPIO_IN,
`endif
    output logic             SEGMENT,
    output logic [IDX_W-1:0] IDX,
    output logic             STOP,
    output logic             PENDING,
    output logic             ERR
);

    localparam logic [15:0] REP_INF  = 16'hFFFF;
    localparam logic [15:0] LOOP_SAT = 16'hFFFE;

    typedef enum logic {RUN, ARMED} state_t;
    typedef enum logic [1:0] {
        M_IMM  = 2'd0,
        M_SYNC = 2'd1,
        M_TIME = 2'd2,
        M_GPIO = 2'd3
    } mode_t;

    generate
        if (SYNC_IDX_TIMEOUT != 0) begin : g_bad_timeout
            $error("SYNC_IDX_TIMEOUT must be 0");
        end
    endgenerate

    state_t           state;
    mode_t            mode_q;
    logic             tgt_q;
    logic [63:0]      trans_q;
    logic [IDX_W-1:0] cyc_sh [2];
    logic [15:0]      div_sh [2];
    logic [15:0]      rep_sh [2];

    logic [IDX_W-1:0] cur_cyc;
    logic [15:0]      cur_div;
    logic [15:0]      cur_rep;
    logic [15:0]      div_cnt;
    logic [15:0]      loop_cnt;

    logic        mode_ok;
    logic        upd_ok;
    logic [15:0] div_max;
    logic        step;
    logic        at_end;
    logic        wrap;
    logic        rep_inf;
    logic        finish;
    logic        cond;
    logic        swap;
    logic        gpio_hit;

`ifdef MOD_SEG_CTRL_GPIO_TRIG_EN
    assign mode_ok = (TRANSITION_MODE <= 8'd3);
`else
    assign mode_ok = (TRANSITION_MODE < 8'd3);
`endif

    assign upd_ok  = UPDATE && mode_ok;
    assign div_max = (cur_div == 16'd0) ? 16'd0 : cur_div - 16'd1;
    assign step    = !STOP && (div_cnt == div_max);
    assign at_end  = (IDX == cur_cyc);
    assign wrap    = step && at_end;
    assign rep_inf = (cur_rep == REP_INF);
    assign finish  = wrap && !rep_inf && (loop_cnt == cur_rep);

    // A finished segment satisfies a SYNC_IDX wait immediately
    always_comb begin
        cond = 1'b0;
        unique case (mode_q)
            M_IMM:  cond = 1'b1;
            M_SYNC: cond = wrap || STOP;
            M_TIME: cond = (SYS_TIME >= trans_q);
            M_GPIO: cond = gpio_hit;
        endcase
    end

    assign swap = (state == ARMED) && !upd_ok && cond;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            mode_q    <= M_IMM;
            tgt_q     <= 1'b0;
            trans_q   <= '0;
            cyc_sh[0] <= '0;
            cyc_sh[1] <= '0;
            div_sh[0] <= '0;
            div_sh[1] <= '0;
            rep_sh[0] <= REP_INF;
            rep_sh[1] <= REP_INF;
            cur_cyc   <= '0;
            cur_div   <= '0;
            cur_rep   <= REP_INF;
            div_cnt   <= '0;
            loop_cnt  <= '0;
            SEGMENT   <= 1'b0;
            IDX       <= '0;
            STOP      <= 1'b0;
            PENDING   <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            ERR <= UPDATE && !mode_ok;
            if (upd_ok) begin
                cyc_sh[0] <= CYCLE0;
                cyc_sh[1] <= CYCLE1;
                div_sh[0] <= FREQ_DIV0;
                div_sh[1] <= FREQ_DIV1;
                rep_sh[0] <= REP0;
                rep_sh[1] <= REP1;
                mode_q    <= mode_t'(TRANSITION_MODE[1:0]);
                tgt_q     <= REQ_RD_SEGMENT;
                trans_q   <= TRANSITION;
                state     <= ARMED;
                PENDING   <= 1'b1;
            end
            if (swap) begin
                state    <= RUN;
                PENDING  <= 1'b0;
                SEGMENT  <= tgt_q;
                cur_cyc  <= cyc_sh[tgt_q];
                cur_div  <= div_sh[tgt_q];
                cur_rep  <= rep_sh[tgt_q];
                IDX      <= '0;
                div_cnt  <= '0;
                loop_cnt <= '0;
                STOP     <= 1'b0;
            end else if (!STOP) begin
                if (step) begin
                    div_cnt <= '0;
                    if (finish) begin
                        STOP <= 1'b1;
                    end else if (at_end) begin
                        IDX <= '0;
                        if (!rep_inf || loop_cnt != LOOP_SAT)
                            loop_cnt <= loop_cnt + 16'd1;
                    end else begin
                        IDX <= IDX + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
        end
    end

`ifdef MOD_SEG_CTRL_GPIO_TRIG_EN
    logic gpio_q;

    // Only rising edges observed while armed count as a trigger
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gpio_q   <= 1'b0;
            gpio_hit <= 1'b0;
        end else begin
            gpio_q <= GPIO_IN;
            if (upd_ok || swap)
                gpio_hit <= 1'b0;
            else if (state == ARMED && mode_q == M_GPIO && GPIO_IN && !gpio_q)
                gpio_hit <= 1'b1;
        end
    end
`else
    assign gpio_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mod_segment_ctrl.sv
// Self-checking bench for mod_segment_ctrl: directed steps plus random
// traffic against an elapsed-time reference model.
module tb_mod_segment_ctrl;

    localparam int IDX_W = 15;
`ifdef MOD_SEG_CTRL_GPIO_TRIG_EN
    localparam bit GPIO_EN = 1'b1;
`else
    localparam bit GPIO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             update = 1'b0;
    logic             req_seg = 1'b0;
    logic [7:0]       mode = 8'd0;
    logic [63:0]      trans = 64'd0;
    logic [63:0]      sys_time = 64'd1000;
    logic [IDX_W-1:0] cyc0 = '0;
    logic [IDX_W-1:0] cyc1 = '0;
    logic [15:0]      div0 = 16'd0;
    logic [15:0]      div1 = 16'd0;
    logic [15:0]      rep0 = 16'd0;
    logic [15:0]      rep1 = 16'd0;
    logic             gpio = 1'b0;
    int               ts_step = 1;

    logic             segment;
    logic [IDX_W-1:0] idx;
    logic             stop;
    logic             pending;
    logic             err;

    int errors = 0;
    int checks = 0;

    mod_segment_ctrl #(.IDX_W(IDX_W), .SYNC_IDX_TIMEOUT(0)) dut (
        .CLK            (clk),
        .RST            (rst),
        .UPDATE         (update),
        .REQ_RD_SEGMENT (req_seg),
        .TRANSITION_MODE(mode),
        .TRANSITION     (trans),
        .CYCLE0         (cyc0),
        .CYCLE1         (cyc1),
        .FREQ_DIV0      (div0),
        .FREQ_DIV1      (div1),
        .REP0           (rep0),
        .REP1           (rep1),
        .SYS_TIME       (sys_time),
`ifdef MOD_SEG_CTRL_GPIO_TRIG_EN
        .GPIO_IN        (gpio),
`endif
        .SEGMENT        (segment),
        .IDX            (idx),
        .STOP           (stop),
        .PENDING        (pending),
        .ERR            (err)
    );

    always #5 clk = ~clk;

    // Reference: index derived from edges elapsed since the last swap
    bit          m_seg, m_armed, m_err, m_gflag, m_gprev, m_tgt;
    longint      m_t;
    int          m_cyc, m_div, m_rep, m_mode;
    logic [63:0] m_trans;
    int          sh_cyc [2];
    int          sh_div [2];
    int          sh_rep [2];

    function automatic longint m_period();
        longint d;
        d = (m_div == 0) ? 1 : longint'(m_div);
        return d * longint'(m_cyc + 1);
    endfunction

    function automatic bit m_stopped();
        if (m_rep == 65535) return 1'b0;
        return m_t >= m_period() * longint'(m_rep + 1);
    endfunction

    function automatic int m_idx();
        longint d;
        if (m_stopped()) return m_cyc;
        d = (m_div == 0) ? 1 : longint'(m_div);
        return int'((m_t / d) % longint'(m_cyc + 1));
    endfunction

    task automatic model_reset();
        m_seg = 0; m_armed = 0; m_err = 0; m_gflag = 0; m_gprev = 0;
        m_tgt = 0; m_t = 0; m_cyc = 0; m_div = 0; m_rep = 65535;
        m_mode = 0; m_trans = 0;
        for (int i = 0; i < 2; i++) begin
            sh_cyc[i] = 0; sh_div[i] = 0; sh_rep[i] = 65535;
        end
    endtask

    task automatic model_step();
        bit valid, upd_ok, cnd, swp, rose;
        valid  = (mode < 8'd3) || (GPIO_EN && mode == 8'd3);
        upd_ok = update && valid;
        case (m_mode)
            0: cnd = 1'b1;
            1: cnd = m_stopped() || ((m_t + 1) % m_period() == 0);
            2: cnd = (sys_time >= m_trans);
            default: cnd = m_gflag;
        endcase
        swp  = m_armed && !upd_ok && cnd;
        rose = gpio && !m_gprev;
        m_gprev = gpio;
        if (upd_ok || swp) m_gflag = 0;
        else if (m_armed && m_mode == 3 && rose) m_gflag = 1;
        if (swp) begin
            m_seg = m_tgt;
            m_cyc = sh_cyc[m_tgt];
            m_div = sh_div[m_tgt];
            m_rep = sh_rep[m_tgt];
            m_t = 0;
            m_armed = 0;
        end else if (!m_stopped()) begin
            m_t++;
        end
        if (upd_ok) begin
            sh_cyc[0] = int'(cyc0); sh_cyc[1] = int'(cyc1);
            sh_div[0] = int'(div0); sh_div[1] = int'(div1);
            sh_rep[0] = int'(rep0); sh_rep[1] = int'(rep1);
            m_mode = int'(mode);
            m_tgt = req_seg;
            m_trans = trans;
            m_armed = 1;
        end
        m_err = update && !valid;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("segment", 64'(segment), 64'(m_seg));
        chk("idx", 64'(idx), 64'(m_idx()));
        chk("stop", 64'(stop), 64'(m_stopped()));
        chk("pending", 64'(pending), 64'(m_armed));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_all();
        sys_time = sys_time + 64'(ts_step);
    endtask

    task automatic upd(int md, bit sg, int c0, int d0, int r0,
                       int c1, int d1, int r1, logic [63:0] tr);
        update = 1'b1;
        mode = 8'(md);
        req_seg = sg;
        cyc0 = IDX_W'(c0); div0 = 16'(d0); rep0 = 16'(r0);
        cyc1 = IDX_W'(c1); div1 = 16'(d1); rep1 = 16'(r1);
        trans = tr;
        tick();
        update = 1'b0;
    endtask

    int n;

    initial begin
        model_reset();
        #2;
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_segment", 64'(segment), 64'd0);
        chk("idle_stop", 64'(stop), 64'd0);

        // Finite repeat: CYCLE=3, FREQ_DIV=2, REP=1
        upd(0, 1'b0, 3, 2, 1, 0, 0, 65535, 64'd0);
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("finite_idx_frozen", 64'(idx), 64'd3);
        chk("finite_stop", 64'(stop), 64'd1);

        // SYNC_IDX swap from a running 10-sample segment
        upd(0, 1'b0, 9, 1, 65535, 5, 3, 2, 64'd0);
        tick();
        n = 0;
        while (m_idx() != 3 && n < 20) begin
            tick();
            n++;
        end
        upd(1, 1'b1, 9, 1, 65535, 5, 3, 2, 64'd0);
        n = 1;
        for (int k = 0; k < 50 && pending; k++) begin
            tick();
            if (pending) n++;
        end
        chk("sync_pending_len", 64'(n), 64'd6);
        chk("sync_segment", 64'(segment), 64'd1);
        chk("sync_idx", 64'(idx), 64'd0);

        // Let seg1 finish, then SYNC_IDX swaps on the next edge
        for (int i = 0; i < 60; i++) tick();
        chk("seg1_stop", 64'(stop), 64'd1);
        upd(1, 1'b0, 4, 1, 0, 5, 3, 2, 64'd0);
        tick();
        chk("sync_stopped_seg", 64'(segment), 64'd0);
        chk("sync_stopped_pend", 64'(pending), 64'd0);
        for (int i = 0; i < 8; i++) tick();

        // SYS_TIME: future target, then a target already passed
        upd(2, 1'b1, 50, 1, 65535, 2, 1, 65535, sys_time + 64'd100);
        n = 1;
        for (int k = 0; k < 200 && pending; k++) begin
            tick();
            if (pending) n++;
        end
        chk("time_pending_len", 64'(n), 64'd100);
        chk("time_segment", 64'(segment), 64'd1);
        upd(2, 1'b0, 50, 1, 65535, 50, 1, 65535, sys_time - 64'd5);
        chk("past_pending", 64'(pending), 64'd1);
        tick();
        chk("past_segment", 64'(segment), 64'd0);
        chk("past_pending_clr", 64'(pending), 64'd0);

        // Invalid mode
        upd(7, 1'b1, 1, 1, 1, 1, 1, 1, 64'd0);
        chk("bad_err", 64'(err), 64'd1);
        tick();
        chk("bad_err_clr", 64'(err), 64'd0);
        chk("bad_segment", 64'(segment), 64'd0);

`ifdef MOD_SEG_CTRL_GPIO_TRIG_EN
        upd(3, 1'b1, 50, 1, 65535, 50, 1, 65535, 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("gpio_wait", 64'(pending), 64'd1);
        gpio = 1'b1;
        tick();
        chk("gpio_seen", 64'(pending), 64'd1);
        tick();
        chk("gpio_segment", 64'(segment), 64'd1);
        chk("gpio_pending", 64'(pending), 64'd0);
        gpio = 1'b0;
`else
        upd(3, 1'b1, 1, 1, 1, 1, 1, 1, 64'd0);
        chk("mode3_err", 64'(err), 64'd1);
        chk("mode3_pending", 64'(pending), 64'd0);
        tick();
`endif

        // Last UPDATE wins
        upd(1, 1'b0, 50, 1, 65535, 50, 1, 65535, 64'd0);
        upd(0, 1'b1, 50, 1, 65535, 7, 2, 65535, 64'd0);
        tick();
        chk("override_segment", 64'(segment), 64'd1);
        chk("override_pending", 64'(pending), 64'd0);
        for (int i = 0; i < 5; i++) tick();

        // Asynchronous reset in the middle of a pending request
        upd(2, 1'b0, 3, 1, 65535, 3, 1, 65535, sys_time + 64'd50);
        tick();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Random traffic
        ts_step = 1;
        for (int i = 0; i < 800; i++) begin
            int r;
            int md;
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                case ($urandom_range(0, 5))
                    0: md = 0;
                    1: md = 1;
                    2: md = 2;
                    3: md = 3;
                    4: md = 1;
                    default: md = int'($urandom_range(4, 255));
                endcase
                update = 1'b1;
                mode = 8'(md);
                req_seg = 1'($urandom_range(0, 1));
                cyc0 = IDX_W'($urandom_range(0, 7));
                cyc1 = IDX_W'($urandom_range(0, 7));
                div0 = 16'($urandom_range(0, 3));
                div1 = 16'($urandom_range(0, 3));
                rep0 = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
                rep1 = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
                trans = sys_time + 64'($urandom_range(0, 60)) - 64'd10;
            end else begin
                update = 1'b0;
            end
            gpio = ($urandom_range(0, 3) == 0) ? ~gpio : gpio;
            ts_step = int'($urandom_range(1, 3));
            if (i == 400) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        update = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
